// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the pixel sensor array.
// Runs erase, expose, convert, turnaround and readout once per start.
module pixel_array_ctrl #(
    parameter int ROW_NUM       = 2,
    parameter int COLUMN_NUM    = 2,
    parameter int ERASE_CYCLES  = 5,
    parameter int EXPOSE_CYCLES = 255,
    parameter int READ_CYCLES   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic                           erase,
    output logic                           expose,
    output logic                           ramp,
    output logic [7:0]                     data_out,
    output logic                           data_oe,
    output logic [ROW_NUM*COLUMN_NUM-1:0]  read,
    input  logic [7:0]                     data_in,
    output logic [7:0]                     pix_data,
    output logic [((ROW_NUM*COLUMN_NUM > 1) ?
                   $clog2(ROW_NUM*COLUMN_NUM) : 1)-1:0] pix_index,
    output logic                           pix_valid,
    output logic                           busy,
    output logic                           done
);

    localparam int N  = ROW_NUM * COLUMN_NUM;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [15:0]   ERASE_LAST  = 16'(ERASE_CYCLES - 1);
    localparam logic [15:0]   EXPOSE_LAST = 16'(EXPOSE_CYCLES - 1);
    localparam logic [15:0]   CONV_LAST   = 16'd255;
    localparam logic [7:0]    READ_LAST   = 8'(READ_CYCLES - 1);
    localparam logic [IW-1:0] K_LAST      = IW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_TURN,
        S_READ,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [15:0]   cnt, cnt_n;
    logic [7:0]    rc, rc_n;
    logic [IW-1:0] k, k_n;
    logic          sample;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rc_n    = rc;
        k_n     = k;
        sample  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ERASE;
                    cnt_n   = '0;
                end
            end
            S_ERASE: begin
                if (cnt == ERASE_LAST) begin
                    state_n = S_EXPOSE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_EXPOSE: begin
                if (cnt == EXPOSE_LAST) begin
                    state_n = S_CONVERT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_CONVERT: begin
                if (cnt == CONV_LAST) begin
                    state_n = S_TURN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_TURN: begin
                state_n = S_READ;
                rc_n    = '0;
                k_n     = '0;
            end
            S_READ: begin
                if (rc == READ_LAST) begin
                    // bus has settled for READ_CYCLES: capture and move on
                    sample = 1'b1;
                    rc_n   = '0;
                    if (k == K_LAST) begin
                        state_n = S_DONE;
                    end else begin
                        k_n = k + IW'(1);
                    end
                end else begin
                    rc_n = rc + 8'd1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // outputs are registered from the next-state decode so they line up
    // with the state they describe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rc        <= '0;
            k         <= '0;
            erase     <= 1'b0;
            expose    <= 1'b0;
            ramp      <= 1'b0;
            data_out  <= '0;
            data_oe   <= 1'b0;
            read      <= '0;
            pix_data  <= '0;
            pix_index <= '0;
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rc        <= rc_n;
            k         <= k_n;
            erase     <= (state_n == S_ERASE);
            expose    <= (state_n == S_EXPOSE);
            ramp      <= (state_n == S_CONVERT);
            data_oe   <= (state_n == S_CONVERT);
            data_out  <= (state_n == S_CONVERT) ? cnt_n[7:0] : 8'd0;
            read      <= (state_n == S_READ) ? (N'(1) << k_n) : '0;
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
            pix_valid <= sample;
            if (sample) begin
                pix_data  <= data_in;
                pix_index <= k;
            end
        end
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl: full frames, ignored starts,
// mid-frame reset and back-to-back frames with per-cycle invariants.
module tb_pixel_array_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       erase, expose, ramp, data_oe;
    logic [7:0] data_out, data_in, pix_data;
    logic [3:0] read;
    logic [1:0] pix_index;
    logic       pix_valid, busy, done;

    int errors = 0;
    int checks = 0;

    int n_er, n_ex, n_ramp, conv_bad, n_pv, n_done, done_at;
    int rd_cnt [4];
    logic [1:0] pv_idx [4];
    logic [7:0] pv_dat [4];
    logic pv_at_done;
    logic found;

    pixel_array_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .erase     (erase),
        .expose    (expose),
        .ramp      (ramp),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .read      (read),
        .data_in   (data_in),
        .pix_data  (pix_data),
        .pix_index (pix_index),
        .pix_valid (pix_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // array model: selected pixel k drives A0+k onto the bus
    always_comb begin
        data_in = 8'h00;
        for (int k = 0; k < 4; k++)
            if (read[k]) data_in = 8'hA0 + 8'(k);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("excl", 32'($countones({erase, expose, ramp, |read}) <= 1), 32'd1);
        chk("oe_read", 32'(data_oe && (read != 0)), 32'd0);
        chk("onehot", 32'($onehot0(read)), 32'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // observe one frame starting at its first erase cycle (c = 1)
    task automatic watch(input bit poke, input bit hold);
        n_er = 0; n_ex = 0; n_ramp = 0; conv_bad = 0;
        n_pv = 0; n_done = 0; done_at = 0; pv_at_done = 0;
        for (int k = 0; k < 4; k++) begin
            rd_cnt[k] = 0;
            pv_idx[k] = 'x;
            pv_dat[k] = 'x;
        end
        for (int c = 1; c <= 700; c++) begin
            if (erase) n_er++;
            if (expose) n_ex++;
            if (ramp) begin
                if (data_out !== 8'(n_ramp)) conv_bad++;
                n_ramp++;
            end
            if (data_oe !== ramp) conv_bad++;
            for (int k = 0; k < 4; k++)
                if (read[k]) rd_cnt[k]++;
            if (pix_valid) begin
                if (n_pv < 4) begin
                    pv_idx[n_pv] = pix_index;
                    pv_dat[n_pv] = pix_data;
                end
                n_pv++;
            end
            if (done) begin
                n_done++;
                done_at = c;
                pv_at_done = pix_valid;
            end
            start = hold | (poke && ((expose && n_ex == 10) ||
                                     (read[0] && rd_cnt[0] == 1)));
            tick();
            if (done_at != 0) break;
        end
    endtask

    task automatic frame_checks(input string tag);
        chk({tag, ".erase_len"}, 32'(n_er), 32'd5);
        chk({tag, ".expose_len"}, 32'(n_ex), 32'd255);
        chk({tag, ".ramp_len"}, 32'(n_ramp), 32'd256);
        chk({tag, ".conv_seq"}, 32'(conv_bad), 32'd0);
        chk({tag, ".done_at"}, 32'(done_at), 32'd526);
        chk({tag, ".n_done"}, 32'(n_done), 32'd1);
        chk({tag, ".n_pv"}, 32'(n_pv), 32'd4);
        chk({tag, ".pv_at_done"}, 32'(pv_at_done), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk({tag, ".rd_len"}, 32'(rd_cnt[k]), 32'd2);
            chk({tag, ".pv_idx"}, 32'(pv_idx[k]), 32'(k));
            chk({tag, ".pv_dat"}, 32'(pv_dat[k]), 32'h0A0 + 32'(k));
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        tick();
        tick();
        chk("rst.outs", 32'({erase, expose, ramp, data_out, data_oe, read,
                             pix_data, pix_index, pix_valid, busy, done}), 0);
        reset = 1'b1;
        tick();
        chk("idle.busy", 32'(busy), 32'd0);

        // plain frame
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("f1.erase0", 32'(erase), 32'd1);
        chk("f1.busy0", 32'(busy), 32'd1);
        watch(1'b0, 1'b0);
        frame_checks("f1");
        chk("f1.busy_end", 32'(busy), 32'd0);
        chk("f1.hold_data", 32'(pix_data), 32'hA3);
        chk("f1.hold_idx", 32'(pix_index), 32'd3);

        // starts during EXPOSE and READ are ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        watch(1'b1, 1'b0);
        frame_checks("f2");
        tick();
        tick();
        chk("f2.no_requeue", 32'(busy | erase), 32'd0);

        // asynchronous reset in the middle of CONVERT
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (ramp && data_out == 8'd100) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("rst.found100", 32'(found), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst.async", 32'({erase, expose, ramp, data_out, data_oe, read,
                              pix_data, pix_index, pix_valid, busy, done}), 0);
        tick();
        tick();
        chk("rst.quiet", 32'({pix_valid, done, busy}), 0);
        reset = 1'b1;
        tick();
        tick();
        chk("rst.after", 32'({pix_valid, done, busy, ramp}), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("f3.erase0", 32'(erase), 32'd1);
        watch(1'b0, 1'b0);
        frame_checks("f3");

        // start held high: back-to-back frames with one idle cycle
        start = 1'b1;
        tick();
        chk("f4.erase0", 32'(erase), 32'd1);
        watch(1'b0, 1'b1);
        frame_checks("f4");
        chk("b2b.gap_busy", 32'(busy), 32'd0);
        chk("b2b.gap_erase", 32'(erase), 32'd0);
        tick();
        chk("b2b.erase", 32'(erase), 32'd1);
        chk("b2b.busy", 32'(busy), 32'd1);
        watch(1'b0, 1'b1);
        start = 1'b0;
        frame_checks("f5");
        tick();
        tick();
        chk("end.idle", 32'(busy | erase), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_array_ctrl.md
Name: pixel_array_ctrl

Overview:
- Sequencer for the 2x2 pixel sensor array.
- Runs one full frame per start pulse: erase, expose, convert, readout.
- During convert it drives the shared 8-bit DATA bus with a code counter while RAMP is high; each pixel latches its code when its comparator trips.
- During readout it selects one pixel at a time and streams the codes out, tagged with the pixel index.

Parameters:
- ROW_NUM, 2, pixel rows in the array.
- COLUMN_NUM, 2, pixel columns; N = ROW_NUM*COLUMN_NUM.
- ERASE_CYCLES, 5, cycles erase is held high (1..65535).
- EXPOSE_CYCLES, 255, cycles expose is held high (1..65535).
- READ_CYCLES, 2, cycles each read select is held before the bus is sampled (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- erase  out  1  to array ERASE.
- expose  out  1  to array EXPOSE.
- ramp  out  1  convert-phase enable to the ramp generator / array RAMP.
- data_out  out  8  counter code driven onto DATA during convert.
- data_oe  out  1  tri-state enable for data_out onto DATA.
- read  out  N  one-hot pixel select; bit k = row-major pixel k.
- data_in  in  8  DATA bus as seen by the controller.
- pix_data  out  8  captured pixel code.
- pix_index  out  clog2(N) (min 1)  index of pix_data.
- pix_valid  out  1  one-cycle strobe, pix_data/pix_index valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (reset=0, async) forces state IDLE.
  - All outputs go to 0: erase, expose, ramp, data_out, data_oe, read, pix_data, pix_index, pix_valid, busy, done.
  - All internal counters clear.
  - Reset mid-frame aborts the frame immediately: no done, no further pix_valid.
- FSM states: IDLE, ERASE, EXPOSE, CONVERT, TURN, READ, DONE.
- All outputs are registered and decoded from the state and counters.
- IDLE:
  - start=1 at edge t moves to ERASE; erase is high from cycle t+1.
  - start is ignored in every other state; no queuing.
- ERASE: erase=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: expose=1 for exactly EXPOSE_CYCLES cycles, then CONVERT.
- CONVERT:
  - ramp=1 and data_oe=1 for exactly 256 cycles.
  - data_out = 0 on the first cycle, incrementing by 1 each cycle to 255 on the last (8-bit binary).
  - No wrap is ever visible; the next state is TURN.
- TURN: one cycle with data_oe=0 and read=0 (bus turnaround). data_oe and any read bit are never high in the same cycle.
- READ, for k = 0..N-1 in order:
  - read = (1<<k) for READ_CYCLES cycles.
  - On the last of these cycles, data_in is sampled.
  - On the next cycle: pix_data = sample, pix_index = k, pix_valid = 1.
  - read advances to bit k+1 in that same cycle, with no gap.
  - After k = N-1, read = 0 and the state moves to DONE.
- DONE: done=1 for one cycle, busy still 1; then IDLE.
  - The pix_valid for k = N-1 coincides with the DONE cycle.
- busy:
  - Rises the cycle after start is accepted, i.e. the same cycle as erase.
  - Falls the cycle after DONE.
- Mutual exclusion: at most one of erase, expose, ramp, (read != 0) is high in any cycle.
- pix_data and pix_index hold their last values between strobes.
- Frame length = ERASE_CYCLES + EXPOSE_CYCLES + 256 + 1 + N*READ_CYCLES + 1 cycles, measured from the first erase cycle to the DONE cycle inclusive.
- A start pulse held high through DONE begins a new frame on the first IDLE edge, one cycle after DONE.

Test Plan:
- Reset, then a start pulse (defaults) -> erase high exactly 5 cycles, then expose high exactly 255 cycles, then ramp/data_oe high 256 cycles with data_out sequence 0,1,…,255; done after 5+255+256+1+8+1 = 526 cycles from the first erase cycle.
- Drive data_in = 8'hA0+k whenever read[k] is high -> four pix_valid strobes with (pix_index, pix_data) = (0,A0), (1,A1), (2,A2), (3,A3); each read bit high exactly 2 cycles, one-hot, none overlapping data_oe.
- Pulse start again during EXPOSE and during READ -> no effect; exactly one done and four pix_valid for the frame.
- Assert reset low during CONVERT at data_out = 100 -> same-instant async clear: all outputs 0, busy 0; a later start runs a complete normal frame from ERASE.
- Hold start high continuously -> back-to-back frames; new erase begins one cycle after DONE; busy low for exactly one cycle between frames.
- Every cycle of the run, check the invariants: erase/expose/ramp/read mutually exclusive, and data_oe never high together with read != 0.
